nmea_frame_ctrl: RTL

NMEA_FRAME_CTRL -- requirements
Module: nmea_frame_ctrl

---
 rtl/nmea_pkg.sv | 36 +++
 rtl/nmea_hex_decode.sv | 25 ++
 rtl/nmea_frame_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nmea_pkg.sv
// nmea_pkg -- shared definitions for the NMEA GGA frame controller.
//   state_t      capture/replay FSM states
//   CH_*         framing characters ($, *, CR, LF)
//   HDR_GPGGA    the five header characters that follow '$'
//   hdr_char()   returns header character idx (0..4) of "GPGGA"
package nmea_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    BODY,
    CS1,
    CS2,
    CR,
    LF,
    REPLAY
  } state_t;

  localparam logic [7:0]  CH_DOLLAR = 8'h24;
  localparam logic [7:0]  CH_STAR   = 8'h2A;
  localparam logic [7:0]  CH_CR     = 8'h0D;
  localparam logic [7:0]  CH_LF     = 8'h0A;
  localparam logic [39:0] HDR_GPGGA = "GPGGA";

  function automatic logic [7:0] hdr_char(input logic [2:0] idx);
    case (idx)
      3'd0:    return HDR_GPGGA[39:32];
      3'd1:    return HDR_GPGGA[31:24];
      3'd2:    return HDR_GPGGA[23:16];
      3'd3:    return HDR_GPGGA[15:8];
      3'd4:    return HDR_GPGGA[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/nmea_hex_decode.sv
// nmea_hex_decode -- combinational ASCII hex digit decoder.
//   i_char   in  8  ASCII character
//   o_valid  out 1  character is 0-9, A-F or a-f
//   o_nib    out 4  decoded nibble (0 when not valid)
module nmea_hex_decode (
  input  logic [7:0] i_char,
  output logic       o_valid,
  output logic [3:0] o_nib
);

  always_comb begin
    o_valid = 1'b0;
    o_nib   = 4'h0;
    if (i_char >= 8'h30 && i_char <= 8'h39) begin
      o_valid = 1'b1;
      o_nib   = i_char[3:0];
    end else if ((i_char >= 8'h41 && i_char <= 8'h46) ||
                 (i_char >= 8'h61 && i_char <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15
      o_valid = 1'b1;
      o_nib   = i_char[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/nmea_frame_ctrl.sv
// nmea_frame_ctrl -- captures "$GPGGA...*hh\r\n" sentences from a UART byte
// stream, validates framing (and optionally the checksum) and replays each
// accepted sentence byte-for-byte to a downstream parser.
//
// Ports
//   sclk        in   1  system clock, rising edge
//   rst         in   1  asynchronous active-high reset
//   rx_data     in   8  received UART byte
//   rx_valid    in   1  rx_data valid for one cycle
//   dataString  out  8  replayed byte
//   dataReady   out  1  dataString valid (high for every replay cycle)
//   replay_busy out  1  FSM is in REPLAY
//   frame_err   out  1  one-cycle pulse on a rejected GGA sentence
//   good_cnt    out 16  accepted sentences, saturating
//   bad_cnt     out 16  rejected GGA sentences, saturating
//   gps_stale   out  1  no accepted sentence within STALE_MS
//
// Build option: define NMEA_CSUM_EN to enforce the XOR checksum. Without it
// the checksum characters must still be hex but their value is not checked.
module nmea_frame_ctrl
  import nmea_pkg::*;
#(
  parameter int SYSCLK_FREQ = 100_000_000,
  parameter int BUF_DEPTH   = 96,
  parameter int STALE_MS    = 2000
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  dataString,
  output logic        dataReady,
  output logic        replay_busy,
  output logic        frame_err,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt,
  output logic        gps_stale
);

  localparam int          AW        = $clog2(BUF_DEPTH);
  localparam int unsigned STALE_CYC = STALE_MS * (SYSCLK_FREQ / 1000);
  localparam int          SW        = $clog2(STALE_CYC + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(BUF_DEPTH - 1);
  localparam logic [SW-1:0] STALE_MAX = SW'(STALE_CYC);
  localparam logic [SW-1:0] STALE_PRE = SW'(STALE_CYC - 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t        r_state, w_next;
  logic [AW-1:0] r_addr;     // next write address
  logic          r_full;     // BUF_DEPTH bytes held
  logic [2:0]    r_hidx;     // header character being matched
  logic [AW-1:0] r_pos;      // byte currently on dataString during replay
  logic [AW-1:0] r_last;     // address of the stored LF
  logic [7:0]    r_data;
  logic          r_ferr;
  logic [15:0]   r_good;
  logic [15:0]   r_bad;
  logic [SW-1:0] r_stale_cnt;
  logic          r_stale;
  logic [7:0]    r_mem [BUF_DEPTH];

  logic          w_dollar;
  logic          w_restart;
  logic          w_reject;
  logic          w_accept;
  logic          w_wr;
  logic          w_xor_en;
  logic          w_cs_hi;
  logic          w_cs_lo;
  logic          w_rep_last;
  logic          w_csum_ok;
  logic          w_hex_vld;
  logic [3:0]    w_hex_nib;
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_rd_addr;

  nmea_hex_decode u_hex (
    .i_char  (rx_data),
    .o_valid (w_hex_vld),
    .o_nib   (w_hex_nib)
  );

  assign w_dollar  = (rx_data == CH_DOLLAR);
  assign w_wr_addr = w_restart ? '0 : r_addr;
  assign w_rd_addr = r_pos + 1'b1;

`ifdef NMEA_CSUM_EN
  logic [7:0] r_xor;
  logic [3:0] r_cs_hi;
  logic [3:0] r_cs_lo;

  assign w_csum_ok = ({r_cs_hi, r_cs_lo} == r_xor);

  // checksum datapath carries no reset: it is re-seeded by every '$'
  always_ff @(posedge sclk) begin
    if (w_restart)     r_xor   <= 8'h00;
    else if (w_xor_en) r_xor   <= r_xor ^ rx_data;
    if (w_cs_hi)       r_cs_hi <= w_hex_nib;
    if (w_cs_lo)       r_cs_lo <= w_hex_nib;
  end
`else
  logic w_unused_csum;

  assign w_csum_ok     = 1'b1;
  assign w_unused_csum = ^{w_hex_nib, w_xor_en, w_cs_hi, w_cs_lo};
`endif

  // FSM state register
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // FSM next state and per-byte actions
  always_comb begin
    w_next     = r_state;
    w_restart  = 1'b0;
    w_reject   = 1'b0;
    w_accept   = 1'b0;
    w_wr       = 1'b0;
    w_xor_en   = 1'b0;
    w_cs_hi    = 1'b0;
    w_cs_lo    = 1'b0;
    w_rep_last = 1'b0;
    case (r_state)
      IDLE: begin
        if (rx_valid && w_dollar) begin
          w_restart = 1'b1;
          w_wr      = 1'b1;
          w_next    = HEADER;
        end
      end
      HEADER: begin
        if (rx_valid) begin
          if (w_dollar) begin
            w_restart = 1'b1;
            w_wr      = 1'b1;
            w_next    = HEADER;
          end else if (rx_data == hdr_char(r_hidx)) begin
            w_wr     = 1'b1;
            w_xor_en = 1'b1;
            if (r_hidx == 3'd4) w_next = BODY;
          end else begin
            w_next = IDLE;
          end
        end
      end
      BODY, CS1, CS2, CR, LF: begin
        if (rx_valid) begin
          if (w_dollar) begin
            // a new sentence aborts the one in progress, which counts as bad
            w_restart = 1'b1;
            w_reject  = 1'b1;
            w_wr      = 1'b1;
            w_next    = HEADER;
          end else if (r_full) begin
            w_reject = 1'b1;
            w_next   = IDLE;
          end else begin
            case (r_state)
              BODY: begin
                w_wr = 1'b1;
                if (rx_data == CH_STAR) w_next   = CS1;
                else                    w_xor_en = 1'b1;
              end
              CS1: begin
                if (w_hex_vld) begin
                  w_wr    = 1'b1;
                  w_cs_hi = 1'b1;
                  w_next  = CS2;
                end else begin
                  w_reject = 1'b1;
                  w_next   = IDLE;
                end
              end
              CS2: begin
                if (w_hex_vld) begin
                  w_wr    = 1'b1;
                  w_cs_lo = 1'b1;
                  w_next  = CR;
                end else begin
                  w_reject = 1'b1;
                  w_next   = IDLE;
                end
              end
              CR: begin
                if (rx_data == CH_CR) begin
                  w_wr   = 1'b1;
                  w_next = LF;
                end else begin
                  w_reject = 1'b1;
                  w_next   = IDLE;
                end
              end
              default: begin
                if (rx_data == CH_LF && w_csum_ok) begin
                  w_wr     = 1'b1;
                  w_accept = 1'b1;
                  w_next   = REPLAY;
                end else begin
                  w_reject = 1'b1;
                  w_next   = IDLE;
                end
              end
            endcase
          end
        end
      end
      REPLAY: begin
        // incoming bytes are deliberately ignored while replaying
        if (r_pos == r_last) begin
          w_rep_last = 1'b1;
          w_next     = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Sentence buffer: written during capture, read during replay, never both
  always_ff @(posedge sclk) begin
    if (w_wr) r_mem[w_wr_addr] <= rx_data;
  end

  // Capture addressing, replay sequencing and status counters
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_full      <= 1'b0;
      r_hidx      <= 3'd0;
      r_pos       <= '0;
      r_last      <= '0;
      r_data      <= 8'h00;
      r_ferr      <= 1'b0;
      r_good      <= 16'h0000;
      r_bad       <= 16'h0000;
      r_stale_cnt <= '0;
      r_stale     <= 1'b1;
    end else begin
      r_ferr <= w_reject;

      if (w_restart) begin
        r_addr <= AW'(1);
        r_full <= 1'b0;
        r_hidx <= 3'd0;
      end else if (w_wr) begin
        if (r_addr == LAST_ADDR) r_full <= 1'b1;
        else                     r_addr <= r_addr + 1'b1;
        if (r_state == HEADER)   r_hidx <= r_hidx + 3'd1;
      end

      // the first replayed byte is always '$', so no buffer read is needed
      // on the cycle that also writes the LF
      if (w_accept) begin
        r_last <= r_addr;
        r_pos  <= '0;
        r_data <= CH_DOLLAR;
      end else if (r_state == REPLAY && !w_rep_last) begin
        r_pos  <= w_rd_addr;
        r_data <= r_mem[w_rd_addr];
      end

      if (w_rep_last) r_good <= sat_inc16(r_good);
      if (w_reject)   r_bad  <= sat_inc16(r_bad);

      // stale timer restarts on every accept event, even with good_cnt pinned
      if (w_rep_last) begin
        r_stale_cnt <= '0;
        r_stale     <= 1'b0;
      end else if (r_stale_cnt != STALE_MAX) begin
        r_stale_cnt <= r_stale_cnt + 1'b1;
        if (r_stale_cnt == STALE_PRE) r_stale <= 1'b1;
      end
    end
  end

  assign dataString  = r_data;
  assign dataReady   = (r_state == REPLAY);
  assign replay_busy = (r_state == REPLAY);
  assign frame_err   = r_ferr;
  assign good_cnt    = r_good;
  assign bad_cnt     = r_bad;
  assign gps_stale   = r_stale;

endmodule
